fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter NOP, default 32'h0000_0013, instruction word driven on d_instr when the queue is empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 f_valid  input  1  fetch word present on f_pc/f_instr this cycle.
REQ-006 f_pc  input  32  PC of fetched word, taken from the PC register output.
REQ-007 f_instr  input  32  instruction word read at f_pc.
REQ-008 flush  input  1  redirect from branch/jump resolution; discard all queued and incoming words.
REQ-009 pc_enable  output  1  advance enable to the PC register.
REQ-010 d_valid  output  1  head entry valid toward decode.
REQ-011 d_pc  output  32  PC of head entry.
REQ-012 d_instr  output  32  instruction of head entry.
REQ-013 d_ready  input  1  decode accepts head entry this cycle.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Storage: circular buffer of DEPTH entries {pc[31:0], instr[31:0]}, write pointer, read pointer, occupancy counter.
REQ-016 full = (count == DEPTH); empty = (count == 0).
REQ-017 pop = d_valid & d_ready & ~flush.
REQ-018 pc_enable = ~flush & (~full | pop), combinational.
REQ-019 push = f_valid & pc_enable; pushed word written at write pointer on the next rising edge.
REQ-020 d_valid = ~empty; d_pc/d_instr combinationally driven from read-pointer entry.
REQ-021 When empty: d_valid = 0, d_pc = 32'h0, d_instr = NOP.
REQ-022 No bypass: a word pushed into an empty queue becomes visible on d_* exactly one cycle after the push edge.
REQ-023 Pointers wrap modulo DEPTH; count never exceeds DEPTH nor drops below 0.
REQ-024 Push only: count +1, write pointer +1. Pop only: count -1, read pointer +1.
REQ-025 Simultaneous push and pop (including while full): count unchanged, both pointers +1, FIFO order preserved.
REQ-026 f_valid while full and no pop: word not stored, pc_enable = 0 so the PC holds and re-presents it.
REQ-027 d_ready while empty: no state change.
REQ-028 flush has priority over push and pop: next edge sets count = 0, both pointers = 0; incoming f_valid word dropped; pc_enable = 0 during the flush cycle.
REQ-029 Cycle after flush: queue empty, pc_enable = 1, normal operation resumes with the redirected PC.
REQ-030 Entry data registers need no reset; only pointers and count are reset.

Reset
REQ-031 rst high asynchronously clears write pointer, read pointer and count to 0, regardless of clk.
REQ-032 While rst high: d_valid = 0, d_pc = 32'h0, d_instr = NOP, count = 0, pc_enable = 1 (when flush = 0).
REQ-033 rst asserted mid-operation discards all entries; first push after deassertion is taken on the first rising edge with rst low.

Verification
REQ-034 Fill: rst released, d_ready = 0, f_valid = 1 for PCs 0x0,0x4,0x8,0xC -> count = 4, pc_enable = 0 after the fourth edge; fifth word (0x10) not stored.
REQ-035 Drain order: from full, d_ready = 1, f_valid = 0 -> d_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, then d_valid = 0, d_instr = 32'h0000_0013.
REQ-036 Full streaming: full queue, f_valid = 1 and d_ready = 1 for 8 cycles -> pc_enable = 1 every cycle, count stays 4, output PCs strictly ascending by 4, pointers wrap twice without loss.
REQ-037 Flush: queue holding 3 entries, flush = 1 with f_valid = 1, d_ready = 1 -> next cycle count = 0, d_valid = 0, neither incoming word nor head consumed; pc_enable = 0 in the flush cycle.
REQ-038 Empty latency: empty queue, single push of {0x100, 0x00500093} -> d_valid = 1 with d_pc = 0x100, d_instr = 0x00500093 one cycle after the push edge, not in the push cycle.
REQ-039 Async reset: assert rst between clock edges with count = 2 -> count = 0 and d_valid = 0 immediately, before the next rising edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
//   Decouples instruction fetch from decode with a small circular buffer of
//   {pc, instr} entries. The queue throttles the PC register through
//   pc_enable so a word presented while the queue is full is simply
//   re-presented on the next cycle. A flush (branch/jump redirect) drops all
//   queued and incoming words in a single cycle.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset (pointers and count only)
//   f_valid    in   fetch word present on f_pc/f_instr
//   f_pc       in   [31:0] PC of the fetched word
//   f_instr    in   [31:0] instruction word read at f_pc
//   flush      in   redirect: discard queued and incoming words
//   pc_enable  out  advance enable to the PC register
//   d_valid    out  head entry valid toward decode
//   d_pc       out  [31:0] PC of the head entry (0 when empty)
//   d_instr    out  [31:0] instruction of the head entry (NOP when empty)
//   d_ready    in   decode accepts the head entry this cycle
//   count      out  [$clog2(DEPTH):0] number of occupied entries
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_valid,
  input  logic [31:0]              f_pc,
  input  logic [31:0]              f_instr,
  input  logic                     flush,
  output logic                     pc_enable,
  output logic                     d_valid,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_instr,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full queue can still accept
  // a word while decode is draining it.
  assign w_pop     = ~w_empty & d_ready & ~flush;
  assign pc_enable = ~flush & (~w_full | w_pop);
  assign w_push    = f_valid & pc_enable;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]    <= f_pc;
      r_instr_mem[r_wptr] <= f_instr;
    end
  end

  // Head is read straight from storage: a word written on an edge into an
  // empty queue appears on d_* only after that edge (no fetch-to-decode bypass).
  always_comb begin
    d_valid = 1'b0;
    d_pc    = 32'h0;
    d_instr = NOP;
    if (!w_empty) begin
      d_valid = 1'b1;
      d_pc    = r_pc_mem[r_rptr];
      d_instr = r_instr_mem[r_rptr];
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        flush;
  logic        pc_enable;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_ready;
  logic [2:0]  count;

  int n_checks;
  int n_errors;

  fetch_queue #(.DEPTH(4), .NOP(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_valid   (f_valid),
    .f_pc      (f_pc),
    .f_instr   (f_instr),
    .flush     (flush),
    .pc_enable (pc_enable),
    .d_valid   (d_valid),
    .d_pc      (d_pc),
    .d_instr   (d_instr),
    .d_ready   (d_ready),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        dr;
    logic        e_pe;
    logic        e_dv;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Default instruction word pattern for a given PC.
  function automatic logic [31:0] iw(input logic [31:0] p);
    return 32'hA000_0000 | p;
  endfunction

  task automatic add(input logic fv, input logic [31:0] pc, input logic fl,
                     input logic dr, input logic e_pe, input logic e_dv,
                     input logic [31:0] e_pc, input logic [2:0] e_cnt);
    vec_t v;
    v.fv    = fv;
    v.pc    = pc;
    v.ins   = (pc == 32'h100) ? 32'h0050_0093 : iw(pc);
    v.fl    = fl;
    v.dr    = dr;
    v.e_pe  = e_pe;
    v.e_dv  = e_dv;
    v.e_pc  = e_dv ? e_pc : 32'h0;
    v.e_ins = e_dv ? ((e_pc == 32'h100) ? 32'h0050_0093 : iw(e_pc)) : NOP;
    v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_pe, input logic e_dv,
                         input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [2:0] e_cnt);
    chk({tag, ".pc_enable"}, {31'h0, pc_enable}, {31'h0, e_pe});
    chk({tag, ".d_valid"},   {31'h0, d_valid},   {31'h0, e_dv});
    chk({tag, ".d_pc"},      d_pc,               e_pc);
    chk({tag, ".d_instr"},   d_instr,            e_ins);
    chk({tag, ".count"},     {29'h0, count},     {29'h0, e_cnt});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    f_valid  = 1'b0;
    f_pc     = 32'h0;
    f_instr  = 32'h0;
    flush    = 1'b0;
    d_ready  = 1'b0;

    //   fv  pc       fl  dr  pe  dv  head     cnt
    // reset state
    add(0, 32'h00,  0, 0, 1, 0, 32'h00,  3'd0);
    // fill
    add(1, 32'h00,  0, 0, 1, 0, 32'h00,  3'd0);
    add(1, 32'h04,  0, 0, 1, 1, 32'h00,  3'd1);
    add(1, 32'h08,  0, 0, 1, 1, 32'h00,  3'd2);
    add(1, 32'h0C,  0, 0, 1, 1, 32'h00,  3'd3);
    add(1, 32'h10,  0, 0, 0, 1, 32'h00,  3'd4);
    add(1, 32'h10,  0, 0, 0, 1, 32'h00,  3'd4);
    // full streaming, 8 cycles
    add(1, 32'h10,  0, 1, 1, 1, 32'h00,  3'd4);
    add(1, 32'h14,  0, 1, 1, 1, 32'h04,  3'd4);
    add(1, 32'h18,  0, 1, 1, 1, 32'h08,  3'd4);
    add(1, 32'h1C,  0, 1, 1, 1, 32'h0C,  3'd4);
    add(1, 32'h20,  0, 1, 1, 1, 32'h10,  3'd4);
    add(1, 32'h24,  0, 1, 1, 1, 32'h14,  3'd4);
    add(1, 32'h28,  0, 1, 1, 1, 32'h18,  3'd4);
    add(1, 32'h2C,  0, 1, 1, 1, 32'h1C,  3'd4);
    // drain, then d_ready while empty
    add(0, 32'h00,  0, 1, 1, 1, 32'h20,  3'd4);
    add(0, 32'h00,  0, 1, 1, 1, 32'h24,  3'd3);
    add(0, 32'h00,  0, 1, 1, 1, 32'h28,  3'd2);
    add(0, 32'h00,  0, 1, 1, 1, 32'h2C,  3'd1);
    add(0, 32'h00,  0, 1, 1, 0, 32'h00,  3'd0);
    add(0, 32'h00,  0, 1, 1, 0, 32'h00,  3'd0);
    // empty latency
    add(1, 32'h100, 0, 0, 1, 0, 32'h00,  3'd0);
    add(0, 32'h00,  0, 0, 1, 1, 32'h100, 3'd1);
    // build to 3 entries, then flush with fetch and decode both active
    add(1, 32'h104, 0, 0, 1, 1, 32'h100, 3'd1);
    add(1, 32'h108, 0, 0, 1, 1, 32'h100, 3'd2);
    add(1, 32'h10C, 1, 1, 0, 1, 32'h100, 3'd3);
    add(1, 32'h200, 0, 0, 1, 0, 32'h00,  3'd0);
    add(0, 32'h00,  0, 0, 1, 1, 32'h200, 3'd1);
    add(1, 32'h204, 0, 0, 1, 1, 32'h200, 3'd1);
    add(0, 32'h00,  0, 0, 1, 1, 32'h200, 3'd2);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      f_valid = vecs[i].fv;
      f_pc    = vecs[i].pc;
      f_instr = vecs[i].ins;
      flush   = vecs[i].fl;
      d_ready = vecs[i].dr;
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_pe, vecs[i].e_dv,
              vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_cnt);
    end

    // Asynchronous reset between edges with two entries held.
    @(negedge clk);
    f_valid = 1'b0;
    flush   = 1'b0;
    d_ready = 1'b0;
    #1;
    chk("arst.pre_count", {29'h0, count}, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk_all("arst.now", 1'b1, 1'b0, 32'h0, NOP, 3'd0);

    // Held in reset across an edge with a word offered: nothing stored.
    @(negedge clk);
    f_valid = 1'b1;
    f_pc    = 32'h300;
    f_instr = iw(32'h300);
    #1;
    chk_all("arst.hold", 1'b1, 1'b0, 32'h0, NOP, 3'd0);

    // First edge with rst low takes the push.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("arst.rel", 1'b1, 1'b0, 32'h0, NOP, 3'd0);
    @(negedge clk);
    f_valid = 1'b0;
    #1;
    chk_all("arst.first", 1'b1, 1'b1, 32'h300, iw(32'h300), 3'd1);

    // Flush while full: pc_enable low even though decode is ready.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      f_valid = 1'b1;
      f_pc    = 32'h400 + 32'(k * 4);
      f_instr = iw(f_pc);
    end
    @(negedge clk);
    f_valid = 1'b1;
    f_pc    = 32'h500;
    d_ready = 1'b1;
    flush   = 1'b1;
    #1;
    chk_all("fullflush.cycle", 1'b0, 1'b1, 32'h300, iw(32'h300), 3'd4);
    @(negedge clk);
    flush   = 1'b0;
    f_valid = 1'b0;
    d_ready = 1'b0;
    #1;
    chk_all("fullflush.after", 1'b1, 1'b0, 32'h0, NOP, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
